// File: rtl/prod_accumulator.sv
// prod_accumulator: sums a burst of 64-bit unsigned products and presents
// {sum, term count, carry-out flag} through a valid/ready output port.
// A burst closes on the in_last beat or when the term counter reaches its
// maximum (2^CNT_W-1). The result is held until the consumer takes it.
// Optional macro ACC_SAT_EN: clamp the accumulator to all ones on carry-out
// instead of wrapping modulo 2^64.
module prod_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state, state_nxt;
  logic [63:0]      acc, acc_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             ovf, ovf_nxt;

  logic             accept;
  logic [64:0]      sum65;
  logic [CNT_W-1:0] count_inc;

  assign accept    = in_valid && in_ready;
  assign sum65     = {1'b0, acc} + {1'b0, in_prod};
  assign count_inc = count + CNT_ONE;

  // Next-state / datapath: load on first beat, add on later beats, close on
  // in_last or when the counter would saturate.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    ovf_nxt   = ovf;
    case (state)
      IDLE: begin
        if (accept) begin
          acc_nxt   = in_prod;
          count_nxt = CNT_ONE;
          ovf_nxt   = 1'b0;
          state_nxt = (in_last || (CNT_ONE == CNT_MAX)) ? HOLD : ACC;
        end
      end
      ACC: begin
        if (accept) begin
`ifdef ACC_SAT_EN
          // Once clamped, any further add carries again (or adds zero), so
          // the accumulator stays at all ones for the rest of the burst.
          acc_nxt = sum65[64] ? '1 : sum65[63:0];
`else
          acc_nxt = sum65[63:0];
`endif
          count_nxt = count_inc;
          ovf_nxt   = ovf | sum65[64];
          state_nxt = (in_last || (count_inc == CNT_MAX)) ? HOLD : ACC;
        end
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State registers; reset wins over any concurrent handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
      ovf   <= ovf_nxt;
    end
  end

  // Outputs come straight from registers, so they are stable while held.
  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign out_sum   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_prod_accumulator.sv
// Bench for prod_accumulator: two instances (CNT_W=8 and CNT_W=2), each with a
// stimulus process, a reference model that sums whole bursts with wide
// arithmetic, and a monitor that compares against an expected-result queue.
// Honours ACC_SAT_EN when defined.
module tb_prod_accumulator;

  typedef struct {
    logic [63:0] sum;
    int          count;
    bit          ovf;
  } exp_t;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : ch
    localparam int W    = (g == 0) ? 8 : 2;
    localparam int MAXT = (1 << W) - 1;

    logic          rst, in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
    logic [63:0]   in_prod, out_sum;
    logic [W-1:0]  out_count;
    exp_t          q[$];
    logic [63:0]   burst[$];
    bit            armed = 0;
    bit            done = 0;
    bit            rdy_rand = 0;

    prod_accumulator #(.CNT_W(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
      .out_ovf(out_ovf)
    );

    // Reference: total of the burst in 72 bits; any carry out of bit 63 at
    // any step means the total reached 2^64.
    function automatic exp_t reduce();
      logic [71:0] t = '0;
      exp_t e;
      foreach (burst[i]) t += 72'(burst[i]);
      e.ovf   = (t[71:64] != 0);
      e.count = burst.size();
`ifdef ACC_SAT_EN
      e.sum = e.ovf ? 64'hFFFF_FFFF_FFFF_FFFF : t[63:0];
`else
      e.sum = t[63:0];
`endif
      return e;
    endfunction

    function automatic logic [63:0] rand_prod();
      logic [63:0] v;
      case ($urandom_range(0, 3))
        0:       v = 64'($urandom_range(0, 1000));
        1:       v = {32'hFFFF_FFFF, 32'($urandom)};
        2:       v = {32'($urandom), 32'($urandom)};
        default: v = '1;
      endcase
      return v;
    endfunction

    task automatic idle(input int n);
      repeat (n) begin
        in_valid = 1'b0;
        in_prod  = {32'($urandom), 32'($urandom)};
        in_last  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    endtask

    task automatic beat(input logic [63:0] p, input bit last);
      bit r = 0;
      in_valid = 1'b1; in_prod = p; in_last = last;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk); r = in_ready;
        @(posedge clk); #1;
        if (r) break;
      end
      in_valid = 1'b0;
      in_prod  = {32'($urandom), 32'($urandom)};
      in_last  = 1'($urandom_range(0, 1));
      if (!r) begin
        checks++; errors++;
        $display("FAIL ch%0d accept_timeout", g);
      end else begin
        burst.push_back(p);
        if (last || burst.size() == MAXT) begin
          q.push_back(reduce());
          burst.delete();
        end
      end
    endtask

    task automatic do_reset();
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete();
      burst.delete();
      armed = 1;
    endtask

    task automatic chk_reset();
      @(negedge clk);
      check($sformatf("ch%0d rst_sum", g),   72'(out_sum),   72'(0));
      check($sformatf("ch%0d rst_count", g), 72'(out_count), 72'(0));
      check($sformatf("ch%0d rst_ovf", g),   72'(out_ovf),   72'(0));
      check($sformatf("ch%0d rst_ready", g), 72'(in_ready),  72'(1));
      @(posedge clk); #1;
    endtask

    task automatic rand_bursts(input int nb, input int maxlen);
      for (int b = 0; b < nb; b++) begin
        int len = $urandom_range(1, maxlen);
        bit use_last = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < len; k++) begin
          beat(rand_prod(), use_last && (k == len - 1));
          if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
      end
      if (burst.size() != 0) beat(rand_prod(), 1'b1);
    endtask

    // Random back-pressure on the result port when enabled.
    initial forever begin
      @(posedge clk); #1;
      if (rdy_rand) out_ready = ($urandom_range(0, 2) != 0);
    end

    // Monitor: a pending expected result means the DUT must be presenting it.
    always @(negedge clk) begin
      if (armed) begin
        check($sformatf("ch%0d out_valid", g), 72'(out_valid), 72'(q.size() != 0));
        check($sformatf("ch%0d in_ready", g),  72'(in_ready),  72'(q.size() == 0));
        if (q.size() != 0) begin
          check($sformatf("ch%0d out_sum", g),   72'(out_sum),   72'(q[0].sum));
          check($sformatf("ch%0d out_count", g), 72'(out_count), 72'(q[0].count));
          check($sformatf("ch%0d out_ovf", g),   72'(out_ovf),   72'(q[0].ovf));
          if (out_ready) void'(q.pop_front());
        end
      end
    end

    initial begin
      rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      do_reset();
      chk_reset();
      out_ready = 1'b1;
      if (W == 8) begin
        // small sum, 3 terms
        beat(64'd6, 0); beat(64'd15, 0); beat(64'd100, 1); idle(3);
        // single-beat burst
        beat(64'hFFFF_FFFE_0000_0001, 1); idle(2);
        // carry out of bit 63
        beat(64'hFFFF_FFFF_FFFF_FFFF, 0); beat(64'd2, 1); idle(2);
        // held result under back-pressure
        out_ready = 1'b0;
        beat(64'd123, 0); beat(64'd456, 1);
        idle(5);
        out_ready = 1'b1;
        idle(3);
        // reset mid-burst discards partial sum
        beat(64'd5, 0); beat(64'd9, 0);
        do_reset(); chk_reset();
        beat(64'd7, 1); idle(2);
        // reset while a result is held
        out_ready = 1'b0;
        beat(64'd11, 1); idle(2);
        do_reset(); chk_reset();
        out_ready = 1'b1;
        // forced close at 255 terms, then a fresh burst
        for (int k = 0; k < 255; k++) beat(64'($urandom_range(0, 1 << 20)), 0);
        beat(64'd3, 1); idle(2);
        rdy_rand = 1;
        rand_bursts(40, 6);
      end else begin
        // forced close after 3 terms; 4th beat opens a new burst
        beat(64'd1, 0); beat(64'd1, 0); beat(64'd1, 0); beat(64'd1, 0);
        idle(2);
        beat(64'd1, 1); idle(2);
        rdy_rand = 1;
        rand_bursts(40, 5);
      end
      rdy_rand = 0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int k = 0; k < 20 && q.size() != 0; k++) begin
        @(posedge clk); #1;
      end
      if (q.size() != 0) begin
        checks++; errors++;
        $display("FAIL ch%0d drain_timeout pending=%0d expected=0", g, q.size());
      end
      idle(2);
      done = 1;
    end
  end

  initial begin
    for (int c = 0; c < 60000; c++) begin
      @(posedge clk);
      if (ch[0].done && ch[1].done) break;
    end
    if (!(ch[0].done && ch[1].done)) begin
      checks++; errors++;
      $display("FAIL run_timeout done0=%0d done1=%0d expected=1", ch[0].done, ch[1].done);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
